mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 2, cycles the memory read/write strobe is held before data is sampled; legal range 1..15.
REQ-002 SHALL have parameter DATA_W, default 32, width of address and data buses.
REQ-003 SHALL have port iClk  in  1  the single clock, rising edge active.
REQ-004 SHALL have port iRst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port iReq0 / iWe0  in  1 / 1  port 0 (instruction fetch) request and write-enable.
REQ-006 SHALL have port iAddr0 / iWData0  in  DATA_W each  port 0 address and write data.
REQ-007 SHALL have port oAck0 / oRData0  out  1 / DATA_W  port 0 completion pulse and read data.
REQ-008 SHALL have ports iReq1, iWe1, iAddr1, iWData1, oAck1, oRData1 with identical widths and meanings for port 1 (data load/store).
REQ-009 SHALL have port oMemAddr  out  DATA_W  shared memory address.
REQ-010 SHALL have port oMemData  out  DATA_W  shared memory write data.
REQ-011 SHALL have port iMemData  in  DATA_W  shared memory read data.
REQ-012 SHALL have ports oMemRead / oMemWrite  out  1 / 1  shared memory strobes.
REQ-013 SHALL have port oBusy  out  1  high while any transaction is in flight.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS and DONE.
REQ-015 IDLE: when any iReqN is high, SHALL grant one port, latch that port's address, write data and write-enable into internal registers, and move to ACCESS; otherwise SHALL stay in IDLE.
REQ-016 Grant SHALL be round-robin: a single requester is always granted; when both request, the port not served last wins.
REQ-017 ACCESS: SHALL drive oMemAddr from the latched address for exactly MEM_LATENCY cycles.
REQ-018 ACCESS: SHALL hold oMemRead (we=0) or oMemWrite (we=1) high for those same MEM_LATENCY cycles, never both.
REQ-019 ACCESS: oMemData SHALL equal the latched write data during writes and zero otherwise.
REQ-020 On the last ACCESS cycle of a read, SHALL register iMemData into oRDataN of the granted port.
REQ-021 DONE: SHALL pulse oAckN of the granted port for exactly one cycle, then return to IDLE.
REQ-022 Timing SHALL be fixed: request seen in IDLE at cycle 0; strobes high in cycles 1..L; ack in cycle L+1; IDLE in cycle L+2. Throughput SHALL be one transaction per L+2 cycles.
REQ-023 oRDataN SHALL hold its value until the next read ack on that port; writes SHALL NOT modify oRDataN.
REQ-024 Requesters SHALL hold req/addr/data stable until ack; the block samples them only in IDLE.
REQ-025 A req dropped mid-transaction SHALL NOT abort it; the ack is still issued.
REQ-026 A req still high in the IDLE cycle after its ack SHALL count as a new request.
REQ-027 Outside ACCESS, oMemAddr, oMemData, oMemRead and oMemWrite SHALL all be 0.
REQ-028 oBusy SHALL be high in ACCESS and DONE only.
REQ-029 The ACCESS counter SHALL be $clog2(MEM_LATENCY+1) bits wide and SHALL reload on every entry to ACCESS.

Reset
REQ-030 On iRst at a clock edge, SHALL go to IDLE and clear all outputs, latched registers and the counter, aborting any transaction with no ack.
REQ-031 On reset, the last-served pointer SHALL be set to port 1, so port 0 wins the first tie.

Structure
REQ-032 A shared package mem_arb_pkg SHALL hold the FSM state enum, the port index constants and the MEM_LATENCY legal-range bound.
REQ-033 A single sub-module arb_rr2 SHALL hold the 2-way round-robin grant logic and the last-served pointer.

Verification
REQ-034 Single read, L=2: iReq0=1, iAddr0=0x0, memory returns 0xDEADBEEF -> oMemRead high cycles 1-2 at addr 0x0; oAck0 pulse cycle 3; oRData0=0xDEADBEEF.
REQ-035 Single write, L=2: iReq1=1, iWe1=1, iAddr1=0x1000, iWData1=0x9 -> oMemWrite high 2 cycles with oMemData=0x9; oMemRead stays 0; oAck1 one pulse; oRData1 unchanged.
REQ-036 Tie after reset: iReq0 and iReq1 asserted together and held through each ack -> grant order 0,1,0,1; no port served twice in a row.
REQ-037 Reset mid-ACCESS: assert iRst in cycle 1 of a read -> next cycle all outputs 0, state IDLE, no oAck0.
REQ-038 Request drop: iReq0 deasserted in cycle 1 -> transaction completes and oAck0 still pulses in cycle L+1.
REQ-039 Latency sweep at L=1 and L=15 -> strobe width equals L and ack arrives in cycle L+1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int MEM_LATENCY_MIN = 1;
  localparam int MEM_LATENCY_MAX = 15;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin grant; the last-served pointer only moves when a grant is taken.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_vld,
  output logic       gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt_vld = |req;
    if (&req) gnt = ~last_q;
    else      gnt = req[1] ? PORT1 : PORT0;
    last_d = last_q;
    if (take && gnt_vld) last_d = gnt;
  end

  // Port 1 counts as last served out of reset so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) last_q <= PORT1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch (port 0) and load/store (port 1) onto one
// fixed-latency memory: IDLE -> ACCESS (MEM_LATENCY cycles) -> DONE (ack).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int DATA_W      = 32
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic              iReq0,
  input  logic              iWe0,
  input  logic [DATA_W-1:0] iAddr0,
  input  logic [DATA_W-1:0] iWData0,
  output logic              oAck0,
  output logic [DATA_W-1:0] oRData0,
  input  logic              iReq1,
  input  logic              iWe1,
  input  logic [DATA_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iWData1,
  output logic              oAck1,
  output logic [DATA_W-1:0] oRData1,
  output logic [DATA_W-1:0] oMemAddr,
  output logic [DATA_W-1:0] oMemData,
  input  logic [DATA_W-1:0] iMemData,
  output logic              oMemRead,
  output logic              oMemWrite,
  output logic              oBusy
);

  localparam int CW = $clog2(MEM_LATENCY + 1);

  if (MEM_LATENCY < MEM_LATENCY_MIN || MEM_LATENCY > MEM_LATENCY_MAX) begin : g_bad_latency
    $error("mem_arbiter: MEM_LATENCY outside 1..15");
  end

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic gnt_vld, gnt, take;

  arb_rr2 u_arb (
    .clk     (iClk),
    .rst     (iRst),
    .req     ({iReq1, iReq0}),
    .take    (take),
    .gnt_vld (gnt_vld),
    .gnt     (gnt)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    port_d   = port_q;
    mem_rd_d = mem_rd_q;
    mem_wr_d = mem_wr_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    take     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          take     = 1'b1;
          port_d   = gnt;
          addr_d   = (gnt == PORT1) ? iAddr1  : iAddr0;
          wdata_d  = (gnt == PORT1) ? iWData1 : iWData0;
          we_d     = (gnt == PORT1) ? iWe1    : iWe0;
          mem_rd_d = ~we_d;
          mem_wr_d = we_d;
          cnt_d    = CW'(MEM_LATENCY);
          state_d  = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - CW'(1);
        // Last strobe cycle: capture read data so it is valid alongside the ack.
        if (cnt_q == CW'(1)) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (!we_q) begin
            if (port_q == PORT1) rdata1_d = iMemData;
            else                 rdata0_d = iMemData;
          end
          if (port_q == PORT1) ack1_d = 1'b1;
          else                 ack0_d = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      port_q   <= PORT0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
      port_q   <= port_d;
      mem_rd_q <= mem_rd_d;
      mem_wr_q <= mem_wr_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign oMemAddr  = (state_q == ST_ACCESS) ? addr_q : '0;
  assign oMemData  = mem_wr_q ? wdata_q : '0;
  assign oMemRead  = mem_rd_q;
  assign oMemWrite = mem_wr_q;
  assign oAck0     = ack0_q;
  assign oAck1     = ack1_q;
  assign oRData0   = rdata0_q;
  assign oRData1   = rdata1_q;
  assign oBusy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench: three arbiters (L=2, L=1, L=15) share a memory model
// returning addr ^ 0xDEADBEEF; one monitor checks bus activity and every ack.
module tb_mem_arbiter;

  typedef struct {
    int          dut;
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 [3];
  logic        req1 [3];
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0 [3];
  logic        ack1 [3];
  logic        mrd  [3];
  logic        mwr  [3];
  logic        busy [3];
  logic [31:0] rdata0 [3];
  logic [31:0] rdata1 [3];
  logic [31:0] maddr  [3];
  logic [31:0] mdata  [3];
  logic [31:0] mrdin  [3];

  exp_t        exp_q [$];
  int          vectors = 0, miscompares = 0;
  bit          mon_en = 1'b0;
  bit          prev_s [3];
  int          width  [3];
  logic [31:0] st_addr [3];
  logic [31:0] st_data [3];
  bit          st_we  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 15;
    mem_arbiter #(.MEM_LATENCY(LAT), .DATA_W(32)) u_dut (
      .iClk(clk), .iRst(rst),
      .iReq0(req0[g]), .iWe0(we0), .iAddr0(addr0), .iWData0(wdata0),
      .oAck0(ack0[g]), .oRData0(rdata0[g]),
      .iReq1(req1[g]), .iWe1(we1), .iAddr1(addr1), .iWData1(wdata1),
      .oAck1(ack1[g]), .oRData1(rdata1[g]),
      .oMemAddr(maddr[g]), .oMemData(mdata[g]), .iMemData(mrdin[g]),
      .oMemRead(mrd[g]), .oMemWrite(mwr[g]), .oBusy(busy[g])
    );
    assign mrdin[g] = maddr[g] ^ 32'hDEADBEEF;
  end

  function automatic int lat_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 1 : 15;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int g = 0; g < 3; g++) begin
        logic s;
        exp_t e;
        s = mrd[g] | mwr[g];
        chk("dual_strobe", 32'(mrd[g] & mwr[g]), 32'd0);
        chk("dual_ack", 32'(ack0[g] & ack1[g]), 32'd0);
        chk("busy", 32'(busy[g]), 32'(s | ack0[g] | ack1[g]));
        if (!s) begin
          chk("idle_addr", maddr[g], 32'd0);
          chk("idle_data", mdata[g], 32'd0);
        end
        if (mrd[g]) chk("read_data_bus", mdata[g], 32'd0);
        if (s) begin
          if (!prev_s[g]) begin
            width[g] = 1; st_addr[g] = maddr[g]; st_data[g] = mdata[g]; st_we[g] = mwr[g];
          end else begin
            width[g]++;
            chk("addr_stable", maddr[g], st_addr[g]);
          end
        end
        if (ack0[g] || ack1[g]) begin
          chk("ack_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ack_dut", 32'(g), 32'(e.dut));
            chk("ack_port", 32'(ack1[g]), 32'(e.port));
            chk("ack_after_strobe", 32'(prev_s[g]), 32'd1);
            chk("strobe_width", 32'(width[g]), 32'(e.lat));
            chk("strobe_we", 32'(st_we[g]), 32'(e.we));
            chk("strobe_addr", st_addr[g], e.addr);
            if (e.we) chk("strobe_wdata", st_data[g], e.wdata);
            chk("rdata", e.port ? rdata1[g] : rdata0[g], e.rdata);
          end
        end
        prev_s[g] = s;
      end
    end
  end

  task automatic xact(int g, bit port, bit we, logic [31:0] addr, logic [31:0] wdata,
                      logic [31:0] rdata, bit drop);
    exp_t e;
    bit got;
    @(negedge clk);
    e.dut = g; e.port = port; e.we = we; e.addr = addr;
    e.wdata = wdata; e.rdata = rdata; e.lat = lat_of(g);
    exp_q.push_back(e);
    if (port) begin we1 = we; addr1 = addr; wdata1 = wdata; req1[g] = 1'b1; end
    else      begin we0 = we; addr0 = addr; wdata0 = wdata; req0[g] = 1'b1; end
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (drop && n == 0) begin req0[g] = 1'b0; req1[g] = 1'b0; end
      if ((port ? ack1[g] : ack0[g]) === 1'b1) got = 1'b1;
    end
    req0[g] = 1'b0; req1[g] = 1'b0;
    chk("ack_timeout", 32'(got), 32'd1);
    if (!got) exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int acks;
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      req0[g] = 1'b0; req1[g] = 1'b0; prev_s[g] = 1'b0; width[g] = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", 32'(busy[g]), 32'd0);
      chk("rst_strobes", 32'({mrd[g], mwr[g]}), 32'd0);
      chk("rst_acks", 32'({ack0[g], ack1[g]}), 32'd0);
      chk("rst_maddr", maddr[g], 32'd0);
      chk("rst_rdata0", rdata0[g], 32'd0);
      chk("rst_rdata1", rdata1[g], 32'd0);
    end
    mon_en = 1'b1;

    // Directed vectors at L=2.
    xact(0, 1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'hDEADBEEF, 1'b0);
    xact(0, 1'b1, 1'b1, 32'h0000_1000, 32'h9,         32'h0000_0000, 1'b0);
    xact(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0,         32'hDEADBEAF, 1'b0);
    xact(0, 1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 32'hDEADBEEF, 1'b0);

    // Tie straight after reset: grants must alternate 0,1,0,1.
    do_reset();
    chk("rst_clears_rdata0", rdata0[0], 32'd0);
    @(negedge clk);
    addr0 = 32'h4; we0 = 1'b0; addr1 = 32'h10; we1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.dut = 0; e.port = i[0]; e.we = 1'b0; e.lat = 2; e.wdata = '0;
      e.addr  = i[0] ? 32'h10 : 32'h4;
      e.rdata = i[0] ? 32'hDEADBEFF : 32'hDEADBEEB;
      exp_q.push_back(e);
    end
    req0[0] = 1'b1; req1[0] = 1'b1;
    acks = 0;
    for (int c = 0; c < 60 && acks < 4; c++) begin
      @(negedge clk);
      if (ack0[0] || ack1[0]) acks++;
    end
    req0[0] = 1'b0; req1[0] = 1'b0;
    chk("tie_acks", 32'(acks), 32'd4);
    if (acks != 4) exp_q.delete();

    // Request dropped in cycle 1 still completes.
    xact(0, 1'b0, 1'b0, 32'h0000_0020, 32'h0, 32'hDEADBECF, 1'b1);

    // Reset in cycle 1 of a read aborts it with no ack.
    @(negedge clk);
    addr0 = 32'h30; we0 = 1'b0; req0[0] = 1'b1;
    @(negedge clk);
    req0[0] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_strobes", 32'({mrd[0], mwr[0]}), 32'd0);
    chk("abort_maddr", maddr[0], 32'd0);
    chk("abort_ack0", 32'(ack0[0]), 32'd0);
    chk("abort_rdata0", rdata0[0], 32'd0);
    repeat (6) @(negedge clk);
    xact(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hDEADBFEF, 1'b0);

    // Latency sweep.
    xact(1, 1'b0, 1'b0, 32'h0000_0000, 32'h0,  32'hDEADBEEF, 1'b0);
    xact(1, 1'b1, 1'b1, 32'h0000_0044, 32'hA5, 32'h0000_0000, 1'b0);
    xact(2, 1'b1, 1'b0, 32'h0000_1000, 32'h0,  32'hDEADAEEF, 1'b0);

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
